wb_ram_arbiter: RTL and testbench

Two-master round-robin Wishbone arbiter sharing a single `ram_wb` slave port. It sits between the AXI-lite-to-Wishbone bridge output (master 0) and a second Wishbone requester such as a DMA or debug port (master 1), and the RAM slave. A grant is held for a whole `cyc` bus cycle. A watchdog terminates any strobe the RAM fails to acknowledge.

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_ram_arbiter_if.sv | 19 +
 rtl/wb_arb_timeout.sv | 28 ++
 rtl/wb_ram_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone RAM arbiter.
package wb_arb_pkg;

    localparam int ARB_NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_ram_arbiter_if.sv
// One Wishbone classic link; "master" is the requester side, "slave" the responder side.
// Handshake: a transfer is pending while cyc & stb are high and completes in the cycle ack or err is high.
interface wb_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic                    ack;
    logic                    err;

    modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
    modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_arb_timeout.sv
// Watchdog for a strobe left unacknowledged: pulses expired when the wait reaches TIMEOUT cycles.
module wb_arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic          w_hit;

    // TIMEOUT of zero leaves the counter free-running but never reports.
    assign w_hit   = (TIMEOUT != 0) && en && !clr && (r_cnt == LIMIT);
    assign expired = w_hit;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr || w_hit) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin arbiter letting two Wishbone masters share one RAM port, grant held per cyc.
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    wb_ram_arbiter_if.slave    m0,
    wb_ram_arbiter_if.slave    m1,
    wb_ram_arbiter_if.master   s,
    output logic [1:0]         grant_o,
    output arb_state_e         state_o
);
    arb_state_e                   r_state;
    logic                         r_last;
    logic [1:0]                   r_grant;
    logic [ARB_NUM_MASTERS-1:0]   w_req;
    logic                         w_sel0;
    logic                         w_sel1;
    logic [ADDR_WIDTH-1:0]        w_adr;
    logic [DATA_WIDTH-1:0]        w_dat;
    logic [DATA_WIDTH/8-1:0]      w_sel;
    logic                         w_we;
    logic                         w_cyc;
    logic                         w_stb;
    logic                         w_wd_en;
    logic                         w_wd_clr;
    logic                         w_expired;
    logic                         w_term_err;

    assign w_req  = {m1.cyc & m1.stb, m0.cyc & m0.stb};
    assign w_sel0 = (r_state == ARB_GNT0);
    assign w_sel1 = (r_state == ARB_GNT1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    // On a tie the master not served last wins.
                    if (w_req[0] && (!w_req[1] || r_last)) begin
                        r_state <= ARB_GNT0;
                        r_last  <= 1'b0;
                        r_grant <= 2'b01;
                    end else if (w_req[1]) begin
                        r_state <= ARB_GNT1;
                        r_last  <= 1'b1;
                        r_grant <= 2'b10;
                    end
                end
                ARB_GNT0: begin
                    if (!m0.cyc) begin
                        r_state <= ARB_IDLE;
                        r_grant <= 2'b00;
                    end
                end
                ARB_GNT1: begin
                    if (!m1.cyc) begin
                        r_state <= ARB_IDLE;
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        w_we  = 1'b0;
        w_cyc = 1'b0;
        w_stb = 1'b0;
        if (w_sel0) begin
            w_adr = m0.adr;
            w_dat = m0.dat_w;
            w_sel = m0.sel;
            w_we  = m0.we;
            w_cyc = m0.cyc;
            w_stb = m0.cyc & m0.stb;
        end else if (w_sel1) begin
            w_adr = m1.adr;
            w_dat = m1.dat_w;
            w_sel = m1.sel;
            w_we  = m1.we;
            w_cyc = m1.cyc;
            w_stb = m1.cyc & m1.stb;
        end
    end

    assign s.adr   = w_adr;
    assign s.dat_w = w_dat;
    assign s.sel   = w_sel;
    assign s.we    = w_we;
    assign s.cyc   = w_cyc;
    assign s.stb   = w_stb;

    assign w_wd_en  = w_stb & ~s.ack & ~s.err;
    assign w_wd_clr = s.ack | s.err | ~w_stb;

    wb_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en      (w_wd_en),
        .clr     (w_wd_clr),
        .expired (w_expired)
    );

    // Responses are gated by the owner's live cyc so an aborted transfer gets nothing back.
    assign w_term_err = s.err | w_expired;
    assign m0.ack   = w_sel0 & w_cyc & s.ack;
    assign m1.ack   = w_sel1 & w_cyc & s.ack;
    assign m0.err   = w_sel0 & w_cyc & w_term_err;
    assign m1.err   = w_sel1 & w_cyc & w_term_err;
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

    assign grant_o = r_grant;
    assign state_o = r_state;
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: grant order, locking, watchdog and reset behaviour.
module tb_wb_ram_arbiter;
    import wb_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant;
    arb_state_e dbg_state;
    int         vectors;
    int         miscompares;
    logic [31:0] exp_q[$];

    wb_ram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
    wb_ram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
    wb_ram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

    wb_ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .grant_o (grant),
        .state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish in time");
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
        m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
        m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = 4'hF;
    endtask

    task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
        m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
        m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = 4'hF;
    endtask

    task automatic clear_all();
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_bus.dat_r = 32'h0; s_bus.ack = 1'b0; s_bus.err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        drive_m0(1'b1, 1'b1, 1'b1, 32'h4, 32'h1);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h8, 32'h2);
        tick(); tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b want 00", grant); end
        vectors++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin miscompares++; $display("FAIL reset_cyc_stb: got %b%b want 00", s_bus.cyc, s_bus.stb); end
        vectors++; if (s_bus.adr !== 32'h0) begin miscompares++; $display("FAIL reset_adr: got %h want 0", s_bus.adr); end
        vectors++; if (dbg_state !== ARB_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        clear_all();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        drive_m0(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        vectors++; if (grant !== 2'b00 || s_bus.stb !== 1'b0) begin miscompares++; $display("FAIL single_pre_grant: got %b/%b want 00/0", grant, s_bus.stb); end
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL single_grant: got %b want 01", grant); end
        vectors++; if (s_bus.cyc !== 1'b1 || s_bus.stb !== 1'b1 || s_bus.we !== 1'b1) begin miscompares++; $display("FAIL single_ctrl: got %b%b%b want 111", s_bus.cyc, s_bus.stb, s_bus.we); end
        vectors++; if (s_bus.adr !== 32'h10) begin miscompares++; $display("FAIL single_adr: got %h want 10", s_bus.adr); end
        vectors++; if (s_bus.dat_w !== 32'hDEADBEEF || s_bus.sel !== 4'hF) begin miscompares++; $display("FAIL single_wdata: got %h/%h want deadbeef/f", s_bus.dat_w, s_bus.sel); end
        s_bus.err = 1'b1;
        #1;
        vectors++; if (m0_bus.err !== 1'b1 || m1_bus.err !== 1'b0) begin miscompares++; $display("FAIL slave_err_route: got m0=%b m1=%b want 1/0", m0_bus.err, m1_bus.err); end
        s_bus.err = 1'b0;
        s_bus.ack = 1'b1;
        #1;
        vectors++; if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin miscompares++; $display("FAIL single_ack: got m0=%b m1=%b want 1/0", m0_bus.ack, m1_bus.ack); end
        tick();
        s_bus.ack = 1'b0;
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        vectors++; if (s_bus.cyc !== 1'b0 || grant !== 2'b01) begin miscompares++; $display("FAIL single_drop: got cyc=%b grant=%b want 0/01", s_bus.cyc, grant); end
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b00 || dbg_state !== ARB_IDLE) begin miscompares++; $display("FAIL single_idle: got grant=%b state=%0d want 00/IDLE", grant, dbg_state); end
    endtask

    task automatic test_tie();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive_m0(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL tie_first: got %b want 01", grant); end
        s_bus.dat_r = 32'hA5A5_5A5A;
        s_bus.ack = 1'b1;
        #1;
        vectors++; if (m0_bus.dat_r !== 32'hA5A5_5A5A || m0_bus.ack !== 1'b1) begin miscompares++; $display("FAIL tie_m0_read: got %h/%b want a5a55a5a/1", m0_bus.dat_r, m0_bus.ack); end
        tick();
        s_bus.ack = 1'b0;
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL tie_bubble: got %b want 00", grant); end
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b10 || s_bus.adr !== 32'h30) begin miscompares++; $display("FAIL tie_second: got %b/%h want 10/30", grant, s_bus.adr); end
        s_bus.ack = 1'b1;
        #1;
        vectors++; if (m1_bus.ack !== 1'b1 || m0_bus.ack !== 1'b0) begin miscompares++; $display("FAIL tie_m1_ack: got m1=%b m0=%b want 1/0", m1_bus.ack, m0_bus.ack); end
        tick();
        s_bus.ack = 1'b0;
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_m0(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
        tick();
        drive_m1(1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL tie_again: got %b want 01", grant); end
        clear_all();
        tick(); tick();
    endtask

    task automatic test_locked();
        drive_m1(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        drive_m0(1'b1, 1'b1, 1'b1, 32'h200, 32'h1234);
        for (int i = 0; i < 4; i++) begin
            drive_m1(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
            exp_q.push_back(32'hC0DE_0000 + 32'(i));
            @(negedge clk);
            s_bus.dat_r = 32'hC0DE_0000 + 32'(i);
            s_bus.ack = 1'b1;
            #1;
            vectors++; if (grant !== 2'b10 || s_bus.adr !== 32'h100 + 32'(i * 4)) begin miscompares++; $display("FAIL locked_owner[%0d]: got %b/%h want 10/%h", i, grant, s_bus.adr, 32'h100 + 32'(i * 4)); end
            vectors++; if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b1) begin miscompares++; $display("FAIL locked_ack[%0d]: got m0=%b m1=%b want 0/1", i, m0_bus.ack, m1_bus.ack); end
            vectors++; if (m1_bus.dat_r !== exp_q[0]) begin miscompares++; $display("FAIL locked_rdata[%0d]: got %h want %h", i, m1_bus.dat_r, exp_q[0]); end
            void'(exp_q.pop_front());
            tick();
            s_bus.ack = 1'b0;
        end
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        vectors++; if (grant !== 2'b10 || m0_bus.ack !== 1'b0) begin miscompares++; $display("FAIL locked_release: got %b/%b want 10/0", grant, m0_bus.ack); end
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL locked_bubble: got %b want 00", grant); end
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b01 || s_bus.adr !== 32'h200) begin miscompares++; $display("FAIL locked_m0_turn: got %b/%h want 01/200", grant, s_bus.adr); end
        clear_all();
        tick(); tick();
    endtask

    task automatic test_timeout();
        drive_m0(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++; if (m0_bus.err !== 1'b0) begin miscompares++; $display("FAIL timeout_early[%0d]: got %b want 0", k, m0_bus.err); end
            tick();
        end
        @(negedge clk);
        vectors++; if (m0_bus.err !== 1'b1 || m1_bus.err !== 1'b0) begin miscompares++; $display("FAIL timeout_pulse: got m0=%b m1=%b want 1/0", m0_bus.err, m1_bus.err); end
        tick();
        for (int k = 9; k < 16; k++) begin
            @(negedge clk);
            vectors++; if (m0_bus.err !== 1'b0) begin miscompares++; $display("FAIL timeout_restart[%0d]: got %b want 0", k, m0_bus.err); end
            tick();
        end
        clear_all();
        tick(); tick();
    endtask

    task automatic test_ack_terminal();
        drive_m0(1'b1, 1'b1, 1'b0, 32'h44, 32'h0);
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++; if (m0_bus.err !== 1'b0) begin miscompares++; $display("FAIL term_early[%0d]: got %b want 0", k, m0_bus.err); end
            tick();
        end
        @(negedge clk);
        s_bus.ack = 1'b1;
        #1;
        vectors++; if (m0_bus.ack !== 1'b1 || m0_bus.err !== 1'b0) begin miscompares++; $display("FAIL term_ack_wins: got ack=%b err=%b want 1/0", m0_bus.ack, m0_bus.err); end
        tick();
        s_bus.ack = 1'b0;
        @(negedge clk);
        vectors++; if (m0_bus.err !== 1'b0) begin miscompares++; $display("FAIL term_after: got %b want 0", m0_bus.err); end
        clear_all();
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        drive_m1(1'b1, 1'b1, 1'b1, 32'h50, 32'h55);
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL rstmid_gnt1: got %b want 10", grant); end
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (s_bus.cyc !== 1'b1) begin miscompares++; $display("FAIL rstmid_before_edge: got cyc=%b want 1", s_bus.cyc); end
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b00 || s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin miscompares++; $display("FAIL rstmid_outputs: got %b cyc=%b stb=%b want 00/0/0", grant, s_bus.cyc, s_bus.stb); end
        vectors++; if (s_bus.adr !== 32'h0 || s_bus.dat_w !== 32'h0 || s_bus.we !== 1'b0 || m1_bus.ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_fields: got adr=%h dat=%h we=%b ack=%b want zeros", s_bus.adr, s_bus.dat_w, s_bus.we, m1_bus.ack); end
        rst_n = 1'b1;
        drive_m0(1'b1, 1'b1, 1'b0, 32'h60, 32'h0);
        tick();
        @(negedge clk);
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL rstmid_tie: got %b want 01", grant); end
        clear_all();
        tick(); tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        clear_all();
        test_reset();
        test_single();
        test_tie();
        test_locked();
        test_timeout();
        test_ack_terminal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
